// File: rtl/comp_job_arbiter.sv
// Round-robin job arbiter that feeds one of two requesters' 16-byte beats into the
// shared LZRW1 compressor core, then waits for core_done or a timeout and reports back.
module comp_job_arbiter #(
  parameter int STRINGSIZE = 350,
  parameter int BEATBYTES  = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   req_start,
  input  logic [1:0]   beat_valid,
  input  logic [255:0] beat_data,
  output logic [1:0]   beat_ready,
  output logic [1:0]   rsp_valid,
  output logic         rsp_timeout,
  output logic         grant_id,
  output logic         busy,
  output logic         core_valid,
  output logic [127:0] core_bytes,
  input  logic         core_done
);

  localparam int NBEATS    = (STRINGSIZE + BEATBYTES - 1) / BEATBYTES;
  localparam int LASTBYTES = STRINGSIZE - (NBEATS - 1) * BEATBYTES;
  localparam int BW        = $clog2(NBEATS + 1);
  localparam int TW        = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0]  LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [TW-1:0]  TO_LIMIT  = TW'(TIMEOUT - 1);
  // Byte lanes beyond the end of the string are blanked on the final beat.
  localparam logic [127:0]   LAST_MASK = {128{1'b1}} >> (8 * (BEATBYTES - LASTBYTES));

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_STREAM,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          ptr_q, ptr_d;
  logic          timeout_q, timeout_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          beat_accept;

  assign beat_accept = (state_q == S_STREAM) && beat_valid[grant_q];

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values computed by the combinational processes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      grant_q    <= 1'b0;
      ptr_q      <= 1'b0;
      timeout_q  <= 1'b0;
      beat_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      timeout_q  <= timeout_d;
      beat_cnt_q <= beat_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // NOTE: every signal gets a hold/default value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    timeout_d  = timeout_q;
    beat_cnt_d = beat_cnt_q;
    to_cnt_d   = to_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req_start) begin
          grant_d    = (req_start == 2'b11) ? ptr_q : req_start[1];
          beat_cnt_d = '0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        // A Done level left over from the previous job must clear first.
        if (!core_done) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (beat_accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            to_cnt_d = '0;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (core_done) begin
          timeout_d = 1'b0;
          state_d   = S_RESP;
        end else if (to_cnt_d == TO_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        ptr_d   = ~grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    beat_ready  = '0;
    rsp_valid   = '0;
    rsp_timeout = 1'b0;
    core_valid  = 1'b0;
    core_bytes  = '0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_STREAM: begin
        beat_ready[grant_q] = 1'b1;
        core_valid          = beat_valid[grant_q];
        if (core_valid) begin
          core_bytes = grant_q ? beat_data[255:128] : beat_data[127:0];
          if (beat_cnt_q == LAST_BEAT) core_bytes = core_bytes & LAST_MASK;
        end
      end
      S_RESP: begin
        rsp_valid[grant_q] = 1'b1;
        rsp_timeout        = timeout_q;
      end
      default: ;
    endcase
  end

  assign grant_id = grant_q;

endmodule

// File: tb/tb_comp_job_arbiter.sv
// Randomized bench for comp_job_arbiter: a driver issues jobs and pushes expected
// beats/responses from a round-robin model; a negedge monitor pops and compares.
module tb_comp_job_arbiter;

  localparam int STRINGSIZE = 350;
  localparam int TIMEOUT    = 4096;
  localparam int NBEATS     = (STRINGSIZE + 15) / 16;
  localparam int NEVER      = 1 << 30;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   req_start = '0;
  logic [1:0]   beat_valid = '0;
  logic [255:0] beat_data = '0;
  logic [1:0]   beat_ready;
  logic [1:0]   rsp_valid;
  logic         rsp_timeout;
  logic         grant_id;
  logic         busy;
  logic         core_valid;
  logic [127:0] core_bytes;
  logic         core_done = 1'b0;

  comp_job_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req_start  (req_start),
    .beat_valid (beat_valid),
    .beat_data  (beat_data),
    .beat_ready (beat_ready),
    .rsp_valid  (rsp_valid),
    .rsp_timeout(rsp_timeout),
    .grant_id   (grant_id),
    .busy       (busy),
    .core_valid (core_valid),
    .core_bytes (core_bytes),
    .core_done  (core_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int id;
    bit to;
    int lat;
  } rsp_t;

  rsp_t         exp_rsp[$];
  logic [127:0] exp_beats[$];
  bit           exp_last[$];
  int           cur_g  = -1;
  int           rr_ptr = 0;

  // Monitor: compares whatever the DUT presents against the queued expectations.
  int           last_cyc = 0;
  int           rsp_cyc  = -10;
  always @(negedge clock) begin
    if (reset) begin
      if (core_valid) begin
        if (exp_beats.size() == 0) begin
          check("extra_beat", 128'(core_valid), 128'(0));
        end else begin
          logic [127:0] eb;
          bit           el;
          eb = exp_beats.pop_front();
          el = exp_last.pop_front();
          check("core_bytes", core_bytes, eb);
          if (el) last_cyc = cyc;
        end
      end
      if (beat_ready != 2'b00) begin
        logic [1:0] er;
        er = (cur_g < 0) ? 2'b00 : (2'b01 << cur_g);
        check("beat_ready", 128'(beat_ready), 128'(er));
      end
      if (rsp_valid != 2'b00) begin
        if (exp_rsp.size() == 0) begin
          check("unexpected_rsp", 128'(rsp_valid), 128'(0));
        end else begin
          rsp_t       r;
          logic [1:0] oh;
          r  = exp_rsp.pop_front();
          oh = 2'b01 << r.id;
          check("rsp_valid", 128'(rsp_valid), 128'(oh));
          check("rsp_timeout", 128'(rsp_timeout), 128'(r.to));
          check("grant_id", 128'(grant_id), 128'(r.id));
          check("rsp_latency", 128'(cyc - last_cyc), 128'(r.lat));
          rsp_cyc = cyc;
        end
      end
      if (cyc == rsp_cyc + 1) check("busy_after_rsp", 128'(busy), 128'(0));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_start = '0;
    beat_valid = '0;
    core_done = 1'b0;
    exp_beats.delete();
    exp_last.delete();
    exp_rsp.delete();
    cur_g = -1;
    rr_ptr = 0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  // One job for requester g: stream NBEATS beats, then raise core_done d cycles
  // after the last beat (never if d >= TIMEOUT).
  task automatic serve(input int g, input logic [1:0] pending, input int gap_beat,
                       input int gap_len, input int d, input int stale,
                       input int abort_beat, output bit aborted);
    logic [127:0] pl [NBEATS];
    logic [127:0] eb;
    rsp_t         r;
    int           n;
    int           other;
    aborted = 1'b0;
    other = 1 - g;
    for (int b = 0; b < NBEATS; b++) pl[b] = {$urandom, $urandom, $urandom, $urandom};
    cur_g = g;
    r.id  = g;
    r.to  = (d + 1 > TIMEOUT);
    r.lat = (d + 1 > TIMEOUT) ? TIMEOUT : d + 1;
    exp_rsp.push_back(r);
    if (pending[other]) begin
      beat_valid[other] = 1'b1;
      beat_data[128*other +: 128] = {$urandom, $urandom, $urandom, $urandom};
    end
    if (stale > 0) begin
      repeat (stale) begin
        @(negedge clock);
        check("stale_ready", 128'(beat_ready), 128'(0));
      end
      tick();
      core_done = 1'b0;
    end
    for (int b = 0; b < NBEATS; b++) begin
      if (b == gap_beat) begin
        beat_valid[g] = 1'b0;
        repeat (gap_len) tick();
      end else if ($urandom_range(0, 3) == 0) begin
        beat_valid[g] = 1'b0;
        tick();
      end
      eb = pl[b];
      for (int k = 0; k < 16; k++)
        if (16 * b + k >= STRINGSIZE) eb[8*k +: 8] = 8'h00;
      exp_beats.push_back(eb);
      exp_last.push_back(b == NBEATS - 1);
      beat_data[128*g +: 128] = pl[b];
      beat_valid[g] = 1'b1;
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!beat_ready[g] && n < 100);
      if (!beat_ready[g]) begin
        check("accept_wait", 128'(beat_ready[g]), 128'(1));
        exp_beats.delete();
        exp_last.delete();
        exp_rsp.delete();
        beat_valid = '0;
        aborted = 1'b1;
        return;
      end
      if (b == abort_beat) begin
        #2;
        reset = 1'b0;
        #1;
        check("rst_beat_ready", 128'(beat_ready), 128'(0));
        check("rst_core_valid", 128'(core_valid), 128'(0));
        check("rst_core_bytes", core_bytes, 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_grant_id", 128'(grant_id), 128'(0));
        check("rst_rsp", 128'({rsp_valid, rsp_timeout}), 128'(0));
        exp_beats.delete();
        exp_last.delete();
        exp_rsp.delete();
        cur_g = -1;
        rr_ptr = 0;
        req_start = '0;
        beat_valid = '0;
        repeat (3) tick();
        reset = 1'b1;
        aborted = 1'b1;
        return;
      end
      tick();
    end
    beat_valid[g] = 1'b0;
    if (d < TIMEOUT) begin
      repeat (d - 1) tick();
      core_done = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (rsp_valid == 2'b00 && n < TIMEOUT + 50);
    if (rsp_valid == 2'b00) begin
      check("rsp_wait", 128'(rsp_valid), 128'(2'b01 << g));
      exp_rsp.delete();
    end
    check("beats_left", 128'(exp_beats.size()), 128'(0));
    tick();
    core_done = 1'b0;
    req_start[g] = 1'b0;
  endtask

  // Raise the requests in mask and serve them in round-robin model order.
  task automatic run_round(input logic [1:0] mask, input int gap_beat, input int gap_len,
                           input int d, input int stale, input int abort_beat);
    logic [1:0] pending;
    int         g;
    bit         ab;
    pending = mask;
    if (stale > 0) core_done = 1'b1;
    req_start = mask;
    while (pending != 2'b00) begin
      g = (pending == 2'b11) ? rr_ptr : (pending[1] ? 1 : 0);
      serve(g, pending, gap_beat, gap_len, d, stale, abort_beat, ab);
      if (ab) return;
      stale = 0;
      pending[g] = 1'b0;
      rr_ptr = 1 - g;
      cur_g = -1;
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_outputs", 128'({beat_ready, rsp_valid, rsp_timeout, grant_id, core_valid}), 128'(0));
    check("reset_core_bytes", core_bytes, 128'(0));
    #2;
    reset = 1'b1;
    tick();

    run_round(2'b01, -1, 0, 30, 0, -1);

    do_reset();
    run_round(2'b11, -1, 0, $urandom_range(5, 40), 0, -1);
    run_round(2'b11, -1, 0, $urandom_range(5, 40), 0, -1);

    run_round(2'b10, 11, 5, 10, 0, -1);

    run_round(2'b01, -1, 0, NEVER, 0, -1);

    run_round(2'b10, -1, 0, 20, 0, 7);
    run_round(2'b10, -1, 0, 20, 0, -1);

    run_round(2'b01, -1, 0, TIMEOUT - 1, 6, -1);

    for (int i = 0; i < 6; i++)
      run_round(2'($urandom_range(1, 3)), $urandom_range(0, NBEATS - 1),
                $urandom_range(0, 4), $urandom_range(1, 60), 0, -1);

    repeat (4) tick();
    check("scoreboard_empty", 128'(exp_rsp.size() + exp_beats.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comp_job_arbiter.md
Name: comp_job_arbiter

Overview:
- Sequences the shared LZRW1 compressor core between two requesters.
- Grants one job at a time using round-robin arbitration.
- Forwards the granted requester's 16-byte input beats to the core, counts beats up to STRINGSIZE bytes, then waits for core_done.
- Returns a per-requester completion pulse, or a timeout error if the core hangs.
- Sits between the testbench/host-side job sources and the compressor core input/Done interface.

Parameters:
- STRINGSIZE, 350, bytes per compression job.
- BEATBYTES, 16, bytes per input beat; fixed at 16 (core bus width).
- TIMEOUT, 4096, max cycles waited for core_done after the last beat.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_start  in  2  per-requester job request, level; held until rsp_valid.
- beat_valid  in  2  per-requester beat valid.
- beat_data  in  256  per-requester beat; requester i uses bits [128*i+127:128*i], byte k at [8k+7:8k].
- beat_ready  out  2  beat accepted this cycle; only the granted bit may be 1.
- rsp_valid  out  2  one-cycle job-complete pulse to the owning requester.
- rsp_timeout  out  1  qualifies rsp_valid: 1 means the job ended by timeout.
- grant_id  out  1  current/last granted requester.
- busy  out  1  high from the GRANT state until RESP completes.
- core_valid  out  1  beat strobe to core.
- core_bytes  out  128  beat data to core; byte lanes as beat_data.
- core_done  in  1  core Done level.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; beat counter 0; round-robin pointer 0 (requester 0 has priority first).
- Beats per job: NBEATS = ceil(STRINGSIZE/16) = 22 for the default. The last beat carries STRINGSIZE mod 16 = 14 valid bytes. The block forces the upper 2 byte lanes of core_bytes to 0 on the last beat.
- IDLE:
  - If any req_start bit is set, pick the requester; on a tie, pick the one the pointer points to.
  - Register grant_id and go to GRANT; busy=1.
  - If no requests, stay in IDLE.
- GRANT: one cycle. Wait here while core_done=1 (stale Done from the previous job). Otherwise go to STREAM.
- STREAM:
  - beat_ready[g] = 1 and all other bits 0.
  - On beat_valid[g]: core_valid=1 and core_bytes=beat_data[g], combinational same cycle, zero added latency; the counter increments.
  - When beat_valid[g]=0: core_valid=0 and the counter holds. Gaps are legal; the core samples only on core_valid.
  - On the accept of beat NBEATS-1, go to WAIT; the timeout counter clears.
- WAIT:
  - beat_ready=0 and core_valid=0.
  - The timeout counter increments each cycle.
  - core_done=1 → RESP with rsp_timeout=0.
  - Counter reaching TIMEOUT-1 without core_done → RESP with rsp_timeout=1.
  - If both happen in the same cycle, done wins (rsp_timeout=0).
- RESP:
  - rsp_valid[g]=1 for exactly one cycle; rsp_timeout is valid that cycle.
  - Pointer becomes ~g.
  - Go to IDLE; busy drops to 0 on entry to IDLE.
  - The requester drops req_start after rsp_valid. A req_start still high in IDLE is treated as a new job.
- Arbitration:
  - Not preemptive.
  - A req_start that falls during GRANT/STREAM/WAIT does not abort the job; the job completes and is still reported.
  - A new request from the non-granted requester waits. It wins next because of the pointer flip.
- Ungranted requesters never see beat_ready=1.
- Counter widths: beat counter is clog2(NBEATS+1) bits; timeout counter is clog2(TIMEOUT+1) bits; no wrap within a job.
- Reset mid-job: immediate return to IDLE with outputs 0; no rsp_valid is issued for the aborted job.
- grant_id holds its value in IDLE.

Test Plan:
1. Single job, requester 0: 22 contiguous beats, with core_done asserted 30 cycles after the last beat.
   - Expect 22 core_valid cycles and bytes 14–15 of beat 21 = 0.
   - Expect rsp_valid=2'b01 once with rsp_timeout=0; busy falls the cycle after.
2. Both req_start bits rise in the same cycle after reset.
   - Requester 0 is served first, then requester 1 with grant_id=1.
   - A third pair of requests goes to requester 0 again.
3. Requester 1 inserts 5 idle cycles after beat 10.
   - core_valid is low during the gap; the counter holds.
   - Total accepted beats = 22, with no extra beat.
4. core_done never asserts.
   - Exactly TIMEOUT (4096) cycles after the last beat: rsp_valid pulse with rsp_timeout=1; the block returns to IDLE.
5. Assert reset while STREAM is at beat 7.
   - All outputs are 0 asynchronously; no rsp_valid.
   - After release, a fresh job streams 22 beats from a counter of 0.
6. core_done held high entering GRANT.
   - The block stays in GRANT until core_done falls, then streams.
   - core_done asserted together with the timeout limit → rsp_timeout=0.
